// File: rtl/orbit_step_sched.sv
// Per-frame orbit integration sequencer: walks each step through r^3, x/y divides,
// velocity and position updates, with done-wait timeout and overrun detection.
module orbit_step_sched #(
    parameter int STEP_W      = 4,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              run,
    input  logic [STEP_W-1:0] steps_per_frame,
    output logic              rad_start,
    input  logic              rad_done,
    output logic              div_start,
    output logic              div_sel,
    input  logic              div_done,
    output logic              acc_we_x,
    output logic              acc_we_y,
    output logic              vel_we,
    output logic              pos_we,
    output logic              busy,
    output logic              frame_done,
    output logic              err_overrun,
    output logic              err_timeout
);

    localparam int WAIT_W = $clog2(DIV_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, RAD, DIV_X, DIV_Y, VEL, POS, DONE
    } state_t;

    state_t            state, state_n;
    logic              entry;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_dec;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              got_done;
    logic              timeout;

    // entry marks the first cycle in a state; starts fire there and dones are ignored there
    always_comb begin
        waiting  = (state == RAD) || (state == DIV_X) || (state == DIV_Y);
        got_done = 1'b0;
        case (state)
            RAD:          got_done = rad_done & ~entry;
            DIV_X, DIV_Y: got_done = div_done & ~entry;
            default:      got_done = 1'b0;
        endcase
        timeout  = waiting && !entry && !got_done &&
                   (wait_cnt == WAIT_W'(DIV_TIMEOUT - 1));
        step_dec = step_cnt - 1'b1;
    end

    always_comb begin
        state_n    = state;
        rad_start  = 1'b0;
        div_start  = 1'b0;
        div_sel    = 1'b0;
        acc_we_x   = 1'b0;
        acc_we_y   = 1'b0;
        vel_we     = 1'b0;
        pos_we     = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: if (frame_tick && run && (steps_per_frame != '0)) state_n = RAD;
            RAD: begin
                rad_start = entry;
                if (got_done) state_n = DIV_X;
            end
            DIV_X: begin
                div_start = entry;
                if (got_done) begin
                    acc_we_x = 1'b1;
                    state_n  = DIV_Y;
                end
            end
            DIV_Y: begin
                div_start = entry;
                div_sel   = 1'b1;
                if (got_done) begin
                    acc_we_y = 1'b1;
                    state_n  = VEL;
                end
            end
            VEL: begin
                vel_we  = 1'b1;
                state_n = POS;
            end
            POS: begin
                pos_we  = 1'b1;
                state_n = (run && (step_dec != '0)) ? RAD : DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (timeout) state_n = IDLE;
        busy = (state != IDLE);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            entry       <= 1'b0;
            step_cnt    <= '0;
            wait_cnt    <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_n;
            entry <= (state_n != state);
            if (state == IDLE && state_n == RAD)
                step_cnt <= steps_per_frame;
            else if (state == POS)
                step_cnt <= step_dec;
            // wait_cnt counts cycles elapsed since the start pulse of the current wait state
            if (waiting) begin
                if (entry) wait_cnt <= '0;
                else       wait_cnt <= wait_cnt + 1'b1;
            end
            if (frame_tick && state != IDLE) err_overrun <= 1'b1;
            if (timeout) err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_orbit_step_sched.sv
// Directed bench for orbit_step_sched: emulated datapath answers each start one cycle later.
module tb_orbit_step_sched;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       run;
    logic [3:0] steps_per_frame;
    logic       rad_start, rad_done, div_start, div_sel, div_done;
    logic       acc_we_x, acc_we_y, vel_we, pos_we;
    logic       busy, frame_done, err_overrun, err_timeout;

    orbit_step_sched #(.STEP_W(4), .DIV_TIMEOUT(64)) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .frame_tick      (frame_tick),
        .run             (run),
        .steps_per_frame (steps_per_frame),
        .rad_start       (rad_start),
        .rad_done        (rad_done),
        .div_start       (div_start),
        .div_sel         (div_sel),
        .div_done        (div_done),
        .acc_we_x        (acc_we_x),
        .acc_we_y        (acc_we_y),
        .vel_we          (vel_we),
        .pos_we          (pos_we),
        .busy            (busy),
        .frame_done      (frame_done),
        .err_overrun     (err_overrun),
        .err_timeout     (err_timeout)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int     n_vec = 0;
    int     n_bad = 0;
    int     cyc_n, n_str, n_pos, n_fd, fd_cycle, onehot_bad, busy_seen;
    int     sel_accx, sel_accy;
    longint order;
    logic   pend_rad, pend_div, rad_en, div_en;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cyc_n = 0; n_str = 0; n_pos = 0; n_fd = 0; fd_cycle = -1;
        onehot_bad = 0; busy_seen = 0; order = 0; sel_accx = -1; sel_accy = -1;
    endtask

    // One clock: drive pending dones, then sample outputs and log strobes
    task automatic cyc();
        int hot;
        @(posedge CLOCK_50);
        #1;
        frame_tick = 1'b0;
        rad_done = pend_rad;
        div_done = pend_div;
        pend_rad = 1'b0;
        pend_div = 1'b0;
        #1;
        cyc_n++;
        hot = int'(rad_start) + int'(div_start) + int'(acc_we_x) + int'(acc_we_y)
            + int'(vel_we) + int'(pos_we);
        if (hot > 1) onehot_bad++;
        if (busy) busy_seen = 1;
        if (rad_start) begin n_str++; order = order * 10 + 1; pend_rad = rad_en; end
        if (div_start) begin n_str++; order = order * 10 + (div_sel ? 4 : 2); pend_div = div_en; end
        if (acc_we_x) begin n_str++; order = order * 10 + 3; sel_accx = int'(div_sel); end
        if (acc_we_y) begin n_str++; order = order * 10 + 5; sel_accy = int'(div_sel); end
        if (vel_we) begin n_str++; order = order * 10 + 6; end
        if (pos_we) begin n_str++; n_pos++; order = order * 10 + 7; end
        if (frame_done) begin n_fd++; fd_cycle = cyc_n; order = order * 10 + 8; end
    endtask

    task automatic start(input int steps, input logic runv);
        clr();
        steps_per_frame = 4'(steps);
        run = runv;
        frame_tick = 1'b1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    function automatic int outs();
        return {rad_start, div_start, div_sel, acc_we_x, acc_we_y, vel_we, pos_we,
                busy, frame_done, err_overrun, err_timeout};
    endfunction

    initial begin
        reset = 1'b1; frame_tick = 1'b0; run = 1'b1; steps_per_frame = 4'd0;
        rad_done = 1'b0; div_done = 1'b0; pend_rad = 1'b0; pend_div = 1'b0;
        rad_en = 1'b1; div_en = 1'b1;
        clr();
        run_cycles(3);
        chk("reset_outs", outs(), 0);
        reset = 1'b0;
        run_cycles(2);
        chk("idle_outs", outs(), 0);

        // single step: full strobe order and latency
        start(1, 1'b1);
        run_cycles(12);
        chk("s1_order", order, 64'd12345678);
        chk("s1_fd_cycle", fd_cycle, 9);
        chk("s1_nstr", n_str, 7);
        chk("s1_onehot", onehot_bad, 0);
        chk("s1_sel_x", sel_accx, 0);
        chk("s1_sel_y", sel_accy, 1);

        // three steps; steps_per_frame changed mid-frame must be ignored
        start(3, 1'b1);
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (cyc_n == 5) steps_per_frame = 4'd1;
        end
        chk("s3_npos", n_pos, 3);
        chk("s3_nfd", n_fd, 1);
        chk("s3_fd_cycle", fd_cycle, 25);
        chk("s3_onehot", onehot_bad, 0);

        // non-qualifying ticks
        start(0, 1'b1);
        run_cycles(12);
        chk("s0_busy", busy_seen, 0);
        chk("s0_nstr", n_str + n_fd, 0);
        start(2, 1'b0);
        run_cycles(12);
        chk("run0_busy", busy_seen, 0);
        chk("run0_nstr", n_str + n_fd, 0);
        chk("no_err", int'({err_overrun, err_timeout}), 0);

        // overrun during step 2
        start(3, 1'b1);
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (cyc_n == 12) frame_tick = 1'b1;
        end
        chk("ovr_flag", int'(err_overrun), 1);
        chk("ovr_npos", n_pos, 3);
        chk("ovr_nfd", n_fd, 1);
        chk("ovr_fd_cycle", fd_cycle, 25);

        // run dropped during step 2 -> step 2 finishes, then DONE
        start(3, 1'b1);
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (cyc_n == 10) run = 1'b0;
        end
        run = 1'b1;
        chk("rundrop_npos", n_pos, 2);
        chk("rundrop_fd_cycle", fd_cycle, 17);
        chk("ovr_sticky", int'(err_overrun), 1);

        // divider never answers -> timeout after 64 wait cycles following div_start at cycle 3
        div_en = 1'b0;
        start(1, 1'b1);
        while (cyc_n < 67) cyc();
        chk("to_busy67", int'(busy), 1);
        chk("to_err67", int'(err_timeout), 0);
        cyc();
        chk("to_busy68", int'(busy), 0);
        chk("to_err68", int'(err_timeout), 1);
        run_cycles(20);
        chk("to_nfd", n_fd, 0);
        chk("to_nstr", n_str, 2);
        chk("to_sticky", int'(err_timeout), 1);
        div_en = 1'b1;

        // asynchronous reset while in DIV_Y
        start(3, 1'b1);
        while (cyc_n < 5) cyc();
        chk("pre_rst_divy", int'({div_start, div_sel}), 3);
        reset = 1'b1;
        #1;
        chk("async_rst_outs", outs(), 0);
        pend_rad = 1'b0;
        pend_div = 1'b0;
        #1;
        reset = 1'b0;
        clr();
        run_cycles(10);
        chk("post_rst_quiet", n_str + n_fd + busy_seen, 0);
        start(1, 1'b1);
        run_cycles(12);
        chk("post_rst_order", order, 64'd12345678);
        chk("post_rst_fd_cycle", fd_cycle, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/orbit_step_sched.md
ORBIT_STEP_SCHED -- requirements
Module: orbit_step_sched

Interface
REQ-001 Parameter STEP_W, default 4: width of the steps-per-frame field.
REQ-002 Parameter DIV_TIMEOUT, default 64: maximum cycles to wait for any datapath done.
REQ-003 CLOCK_50  in  1  sole clock, all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 frame_tick  in  1  one-cycle pulse at start of vertical blanking.
REQ-006 run  in  1  level: 1 = integration enabled.
REQ-007 steps_per_frame  in  STEP_W  integration steps per frame; 0 = none.
REQ-008 rad_start  out  1  one-cycle pulse: datapath computes r^3 from x,y.
REQ-009 rad_done  in  1  one-cycle pulse: r^3 valid.
REQ-010 div_start  out  1  one-cycle pulse to shared divider.
REQ-011 div_sel  out  1  divider operand select: 0 = x axis, 1 = y axis; held stable while waiting.
REQ-012 div_done  in  1  one-cycle pulse: quotient valid.
REQ-013 acc_we_x / acc_we_y  out  1 each  one-cycle write strobes for ax / ay.
REQ-014 vel_we  out  1  one-cycle strobe: vx+=ax*dt, vy+=ay*dt.
REQ-015 pos_we  out  1  one-cycle strobe: x+=vx*dt, y+=vy*dt.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 frame_done  out  1  one-cycle pulse after last step of a frame.
REQ-018 err_overrun  out  1  sticky: frame_tick arrived while busy.
REQ-019 err_timeout  out  1  sticky: done wait exceeded DIV_TIMEOUT.

Function
REQ-020 States: IDLE, RAD, DIV_X, DIV_Y, VEL, POS, DONE.
REQ-021 IDLE -> RAD when frame_tick=1, run=1, steps_per_frame!=0; step counter loads steps_per_frame same cycle; otherwise remain IDLE.
REQ-022 Entry to RAD: rad_start pulses exactly one cycle (first RAD cycle); RAD -> DIV_X on rad_done.
REQ-023 Entry to DIV_X: div_start pulses one cycle with div_sel=0; on div_done, acc_we_x pulses the same cycle and state -> DIV_Y.
REQ-024 Entry to DIV_Y: div_start pulses one cycle with div_sel=1; on div_done, acc_we_y pulses the same cycle and state -> VEL.
REQ-025 VEL lasts one cycle with vel_we=1, -> POS; POS lasts one cycle with pos_we=1, counter decrements.
REQ-026 POS -> RAD if decremented count !=0, else -> DONE; DONE lasts one cycle with frame_done=1, -> IDLE.
REQ-027 Done pulses arriving in the cycle of the corresponding start or in states not awaiting them are ignored.
REQ-028 At most one of rad_start, div_start, acc_we_x, acc_we_y, vel_we, pos_we is high in any cycle.
REQ-029 Wait counter (width clog2(DIV_TIMEOUT+1)) clears on each start pulse, increments each waiting cycle; reaching DIV_TIMEOUT without done -> err_timeout=1, state -> IDLE, no frame_done, no further strobes.
REQ-030 frame_tick while busy: err_overrun=1, tick dropped, current sequence continues unaffected.
REQ-031 run deasserted mid-frame: current step completes through POS, then -> DONE regardless of count.
REQ-032 steps_per_frame sampled only at IDLE->RAD; later changes take effect next frame.
REQ-033 Per-step latency with single-cycle done responses: RAD..POS = 8 cycles; frame of N steps ends with frame_done at cycle 8N+1 after tick.
REQ-034 Sticky errors clear only on reset.

Reset
REQ-035 reset=1 forces state IDLE, counters 0, all outputs 0 (div_sel=0) immediately, independent of clock.
REQ-036 reset asserted mid-sequence abandons the step; no strobe emitted after reset release until next qualifying frame_tick.

Verification
REQ-037 steps=1, run=1, tick, rad_done/div_done returned 1 cycle after each start -> strobe order rad_start, div_start(sel0), acc_we_x, div_start(sel1), acc_we_y, vel_we, pos_we, frame_done; exactly one each.
REQ-038 steps=3 -> three pos_we pulses, one frame_done at cycle 25 after tick.
REQ-039 steps=0 or run=0 at tick -> busy stays 0, no strobes.
REQ-040 Second tick during step 2 of steps=3 -> err_overrun=1, still exactly 3 pos_we, one frame_done.
REQ-041 div_done withheld, DIV_TIMEOUT=64 -> err_timeout=1 after 64 wait cycles, state IDLE, no frame_done; sticky until reset.
REQ-042 reset pulse while in DIV_Y -> all outputs 0 asynchronously, busy=0, errors cleared; next tick runs full sequence normally.
